// File: rtl/tag_free_list.sv
// -----------------------------------------------------------------------------
// tag_free_list
//
// Physical-tag allocator for the rename stage. Hands out the lowest-index free
// physical tags to the rename slots each cycle, takes back the previous tags
// displaced at commit, and keeps a committed copy of the allocation bitmap.
// A branch mispredict restores the speculative bitmap from that copy in one
// cycle.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   IN_mispred          roll speculative allocations back to committed state
//   IN_issueValid       per rename slot: consume the offered tag this cycle
//   OUT_issueTags       per rename slot offered tag (NO_TAG when none)
//   OUT_issueTagsValid  per rename slot: offered tag is genuine
//   IN_commitValid      per commit slot: slot active
//   IN_commitNewTag     per commit slot: tag becoming architectural
//   IN_commitPrevTag    per commit slot: displaced tag, now free
//   OUT_freeCount       registered count of speculatively free tags
// -----------------------------------------------------------------------------
module tag_free_list #(
    parameter int NUM_ISSUE  = 4,
    parameter int NUM_COMMIT = 4,
    parameter int NUM_TAGS   = 64,
    parameter int TAG_SIZE   = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           IN_mispred,
    input  logic [NUM_ISSUE-1:0]           IN_issueValid,
    output logic [NUM_ISSUE*TAG_SIZE-1:0]  OUT_issueTags,
    output logic [NUM_ISSUE-1:0]           OUT_issueTagsValid,
    input  logic [NUM_COMMIT-1:0]          IN_commitValid,
    input  logic [NUM_COMMIT*TAG_SIZE-1:0] IN_commitNewTag,
    input  logic [NUM_COMMIT*TAG_SIZE-1:0] IN_commitPrevTag,
    output logic [TAG_SIZE-1:0]            OUT_freeCount
);

    localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam logic [TAG_SIZE-1:0] NO_TAG = {1'b1, {(TAG_SIZE-1){1'b0}}};

    // Decode a tag into a one-hot bitmap; a disabled request or a tag with
    // its "no physical register" MSB set yields an all-zero mask.
    function automatic logic [NUM_TAGS-1:0] tag_onehot(
        input logic [TAG_SIZE-1:0] tag,
        input logic                en
    );
        logic [NUM_TAGS-1:0] mask_v;
        mask_v = {{(NUM_TAGS-1){1'b0}}, 1'b1} << tag[IDX_W-1:0];
        return mask_v & {NUM_TAGS{en & ~tag[TAG_SIZE-1]}};
    endfunction

    // Number of zero bits in a tag bitmap, i.e. free tags.
    function automatic logic [TAG_SIZE-1:0] count_free(
        input logic [NUM_TAGS-1:0] used
    );
        logic [TAG_SIZE-1:0] cnt_v;
        cnt_v = {TAG_SIZE{1'b0}};
        for (int t = 0; t < NUM_TAGS; t++) begin
            cnt_v = cnt_v + {{(TAG_SIZE-1){1'b0}}, ~used[t]};
        end
        return cnt_v;
    endfunction

    logic [NUM_TAGS-1:0] spec_used_r;
    logic [NUM_TAGS-1:0] com_used_r;
    logic [TAG_SIZE-1:0] free_count_r;

    logic [TAG_SIZE-1:0] offer_tag_s   [NUM_ISSUE];
    logic [NUM_ISSUE-1:0] offer_valid_s;

    logic [NUM_TAGS-1:0] clear_mask_s;
    logic [NUM_TAGS-1:0] com_set_mask_s;
    logic [NUM_TAGS-1:0] alloc_mask_s;
    logic [NUM_TAGS-1:0] spec_next_s;
    logic [NUM_TAGS-1:0] com_next_s;

    // Offer selection: walk the tags in index order; slot i takes the free
    // tag seen when exactly i free tags have already been passed.
    always_comb begin
        logic [TAG_SIZE-1:0] seen_v;
        logic                hit_v;
        seen_v = {TAG_SIZE{1'b0}};
        hit_v  = 1'b0;
        for (int i = 0; i < NUM_ISSUE; i++) begin
            offer_tag_s[i]   = NO_TAG;
            offer_valid_s[i] = 1'b0;
        end
        for (int t = 0; t < NUM_TAGS; t++) begin
            for (int i = 0; i < NUM_ISSUE; i++) begin
                hit_v            = ~spec_used_r[t] & (seen_v == TAG_SIZE'(i));
                offer_tag_s[i]   = hit_v ? TAG_SIZE'(t) : offer_tag_s[i];
                offer_valid_s[i] = hit_v | offer_valid_s[i];
            end
            seen_v = seen_v + {{(TAG_SIZE-1){1'b0}}, ~spec_used_r[t]};
        end
    end

    // Next-state bitmaps. Commit clears go first, then commit/allocate sets;
    // a mispredict overrides the speculative map with the updated committed
    // map, which also discards this cycle's allocations.
    always_comb begin
        clear_mask_s   = {NUM_TAGS{1'b0}};
        com_set_mask_s = {NUM_TAGS{1'b0}};
        alloc_mask_s   = {NUM_TAGS{1'b0}};
        for (int i = 0; i < NUM_COMMIT; i++) begin
            clear_mask_s   = clear_mask_s |
                tag_onehot(IN_commitPrevTag[i*TAG_SIZE +: TAG_SIZE], IN_commitValid[i]);
            com_set_mask_s = com_set_mask_s |
                tag_onehot(IN_commitNewTag[i*TAG_SIZE +: TAG_SIZE], IN_commitValid[i]);
        end
        for (int i = 0; i < NUM_ISSUE; i++) begin
            alloc_mask_s = alloc_mask_s |
                tag_onehot(offer_tag_s[i], IN_issueValid[i] & offer_valid_s[i]);
        end
        com_next_s  = (com_used_r & ~clear_mask_s) | com_set_mask_s;
        spec_next_s = IN_mispred ? com_next_s
                                 : ((spec_used_r & ~clear_mask_s) | alloc_mask_s);
    end

    // State registers; the free count is taken from the next speculative map
    // so it lines up with the offers of the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_used_r  <= {NUM_TAGS{1'b0}};
            com_used_r   <= {NUM_TAGS{1'b0}};
            free_count_r <= TAG_SIZE'(NUM_TAGS);
        end else begin
            spec_used_r  <= spec_next_s;
            com_used_r   <= com_next_s;
            free_count_r <= count_free(spec_next_s);
        end
    end

    // Pack the per-slot offers onto the flat output buses.
    always_comb begin
        OUT_issueTags = {(NUM_ISSUE*TAG_SIZE){1'b0}};
        for (int i = 0; i < NUM_ISSUE; i++) begin
            OUT_issueTags[i*TAG_SIZE +: TAG_SIZE] = offer_tag_s[i];
        end
        OUT_issueTagsValid = offer_valid_s;
        OUT_freeCount      = free_count_r;
    end

endmodule

// File: doc/tag_free_list.md
# tag_free_list

Physical-tag allocator that feeds the rename stage. It hands out free physical register tags for each renamed destination and takes back the previous tags that the rename table returns at commit. It keeps a speculative and a committed allocation bitmap so a branch mispredict rolls back all speculative allocations in one cycle. It sits beside the rename table: its offered tags drive the rename table's issue-tag inputs, and the rename table's commit previous-tag outputs drive its free port.

## Interface
- NUM_ISSUE, 4, rename slots per cycle
- NUM_COMMIT, 4, commit slots per cycle
- NUM_TAGS, 64, physical tags; must be a power of two, at most 2^(TAG_SIZE-1)
- TAG_SIZE, 7, tag width; MSB set (e.g. 7'h40) means "no physical register"

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- IN_mispred  in  1  roll speculative state back to committed state
- IN_issueValid  in  NUM_ISSUE  slot i consumes its offered tag this cycle
- OUT_issueTags  out  NUM_ISSUE*TAG_SIZE  offered tag per slot, MSB always 0
- OUT_issueTagsValid  out  NUM_ISSUE  offered tag of slot i is genuine
- IN_commitValid  in  NUM_COMMIT  commit slot i active
- IN_commitNewTag  in  NUM_COMMIT*TAG_SIZE  tag becoming architectural
- IN_commitPrevTag  in  NUM_COMMIT*TAG_SIZE  tag displaced and now free
- OUT_freeCount  out  TAG_SIZE  registered number of speculatively free tags

## Operation
- State per tag t:
  - specUsed[t]: allocated since reset or last rollback.
  - comUsed[t]: architecturally live.
- Offer: slot i is offered the i-th lowest-index tag with specUsed == 0. This is computed combinationally from the current state only.
  - OUT_issueTagsValid[i] = 1 iff at least i+1 free tags exist.
  - When not valid, OUT_issueTags[i] = 7'h40.
- Allocate: at the clock edge, for each i with IN_issueValid[i] and OUT_issueTagsValid[i], set specUsed[OUT_issueTags[i]].
  - IN_issueValid[i] with an invalid offer is ignored; it is a protocol error and the rename stage must stall instead.
  - Slots are independent; gaps (e.g. valid = 4'b0101) are legal.
- Commit: for each i with IN_commitValid[i]:
  - If IN_commitPrevTag MSB = 0, clear specUsed and comUsed of that tag.
  - If IN_commitNewTag MSB = 0, set comUsed of that tag.
  - Tags with MSB = 1 are ignored on both fields.
- Mispred: specUsed <= comUsed for all tags. The comUsed value used is the one after this cycle's commit updates. All allocations in the same cycle are suppressed.
- Precedence within one cycle, per tag bit:
  - Commit-clear is applied first.
  - Then commit-set and allocate-set.
  - Then mispred copy.
- OUT_freeCount <= popcount(~next specUsed). Width TAG_SIZE holds NUM_TAGS exactly (64 fits in 7 bits).

## Timing
- Reset (rst = 0, async):
  - specUsed = 0 and comUsed = 0 for all tags.
  - OUT_freeCount = NUM_TAGS.
  - Offers are tags 0..NUM_ISSUE-1, all valid.
- Offer latency: 0. Outputs are combinational from registered state.
- Allocation takes effect at the next edge. A consumed tag is never re-offered in the following cycle.
- A freed tag is offered no earlier than the cycle after its commit edge. It is never offered in the same cycle it is freed.
- Mispred: offers in the next cycle reflect the rolled-back state. OUT_freeCount updates on the same edge.
- Reset release mid-operation: all in-flight allocations are discarded. The first cycle after release behaves as a fresh reset.
- Full: with 0 free tags, all OUT_issueTagsValid = 0 and all offers are 7'h40.

## Test plan
- Reset, then request all slots (IN_issueValid = 4'hF) in 16 consecutive cycles -> offers 0-3, 4-7, ..., 60-63. After that, OUT_issueTagsValid = 0 and OUT_freeCount = 0.
- From reset, issue 4'b1010 -> tags 1 and 3 consumed. Next offer is 0, 2, 4, 5; OUT_freeCount = 62.
- Allocate tags 0-7. Commit slot 0 with newTag = 5, prevTag = 7'h40. Then assert IN_mispred -> specUsed is only {5}. Next offer is 0, 1, 2, 3; OUT_freeCount = 63.
- Full table, and the same cycle commit prevTag = 9 with IN_issueValid = 4'hF -> no allocation this cycle. Next cycle, slot 0 is offered 9 with valid = 4'b0001.
- In one cycle: mispred + issue 4'hF + commit newTag 2 / prevTag 3 (both previously allocated and committed) -> no allocation. After rollback tag 2 is used and tag 3 is free.
- Assert rst low mid-burst (not edge-aligned) -> outputs return to reset values immediately, and OUT_freeCount = 64 while rst is low.
